// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Serial 8N1 receiver with a small receive FIFO and a pop interface.
// The receive side of the SoC UART. The line is synchronised, then sampled
// in the middle of each bit. Complete bytes go into a circular FIFO. The MMU
// maps the FIFO head onto a data register and the flags onto a status register.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per serial bit (>= 8)
//   FIFO_DEPTH   : receive FIFO entries (power of two, >= 2)
//
// Ports
//   clk        : system clock
//   rst        : synchronous reset, active-high
//   rx         : asynchronous serial line, idle high
//   read_en    : pop one byte from the FIFO head
//   clear_err  : clear the sticky error flags
//   data       : FIFO head byte, 0x00 when the FIFO is empty
//   rx_valid   : FIFO not empty
//   rx_full    : FIFO full
//   frame_err  : sticky, a stop bit was sampled low
//   overrun    : sticky, a byte arrived while the FIFO was full and was dropped
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       read_en,
    input  logic       clear_err,
    output logic [7:0] data,
    output logic       rx_valid,
    output logic       rx_full,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [FCNT_W-1:0] DEPTH_C  = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } state_e;

    // ---------------------------------------------------------------- state
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   count_q, count_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          mem_q [FIFO_DEPTH];

    logic rx_s;
    logic push;
    logic frame_evt;
    logic pop;
    logic fifo_full;
    logic mem_we;
    logic overrun_evt;

    // Two-flop synchroniser. The FSM looks only at rx_s.
    assign sync1_d = rx;
    assign sync2_d = sync1_q;
    assign rx_s    = sync2_q;

    // ------------------------------------------------------------ receiver FSM
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_evt = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                // Check the line again in the middle of the start bit, so a short low glitch is ignored.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};   // LSB arrives first
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_evt = 1'b1;
                        state_d   = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                // Hold here while the line stays low, so a break gives only one frame error.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------- FIFO
    assign fifo_full = (count_q == DEPTH_C);
    assign pop       = read_en && (count_q != '0);

    always_comb begin
        mem_we      = 1'b0;
        overrun_evt = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        // When the FIFO is full, a pop in the same cycle frees the head slot.
        // That slot is where wr_ptr points, so the push can still go ahead.
        if (push && (pop || !fifo_full)) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (push && !pop && fifo_full) begin
            overrun_evt = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (mem_we && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!mem_we && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Sticky flags: a new error in the same cycle as clear_err leaves the flag set.
    assign frame_err_d = (frame_err_q && !clear_err) || frame_evt;
    assign overrun_d   = (overrun_q && !clear_err) || overrun_evt;

    // --------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the edge.
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // NOTE: the storage array has no reset. count gates every read, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // ----------------------------------------------------------------- outputs
    assign data      = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign rx_valid  = (count_q != '0);
    assign rx_full   = fifo_full;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed self-checking bench for uart_rx with CLKS_PER_BIT=16 and FIFO_DEPTH=4.
// Frames are driven one bit every 16 clocks. Outputs are sampled 1 ns after a
// rising edge.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       read_en;
    logic       clear_err;
    logic [7:0] data;
    logic       rx_valid;
    logic       rx_full;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    logic rv_prev = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .read_en   (read_en),
        .clear_err (clear_err),
        .data      (data),
        .rx_valid  (rx_valid),
        .rx_full   (rx_full),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle in which rx_valid rises. Used for the latency check.
    always @(negedge clk) begin
        if (rx_valid && !rv_prev) rise_cyc = cyc;
        rv_prev = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one 8N1 frame. If pop_at_stop is set, read_en is high during the
    // stop-sample cycle, 155 clocks after the start edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic pop_at_stop);
        @(posedge clk); #1;
        start_cyc = cyc;
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = stop_bit;
        repeat (10) @(posedge clk);
        #1;
        if (pop_at_stop) read_en = 1'b1;
        @(posedge clk); #1;
        read_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pulse_read();
        @(posedge clk); #1;
        read_en = 1'b1;
        @(posedge clk); #1;
        read_en = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},      data,      32'h00);
        check({tag, "_rx_valid"},  rx_valid,  32'h0);
        check({tag, "_rx_full"},   rx_full,   32'h0);
        check({tag, "_frame_err"}, frame_err, 32'h0);
        check({tag, "_overrun"},   overrun,   32'h0);
    endtask

    initial begin
        int lat;
        logic [7:0] fill [5];
        logic [7:0] sp   [4];
        fill = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        sp   = '{8'h22, 8'h33, 8'h44, 8'h99};

        rx = 1'b1; read_en = 1'b0; clear_err = 1'b0; rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_outputs("reset");

        // Single byte.
        send_frame(8'hA5, 1'b1, 1'b0);
        lat = rise_cyc - start_cyc;
        check("a5_latency_ok", (lat > 0 && lat <= 9 * CPB + CPB / 2 + 4), 32'h1);
        check("a5_rx_valid", rx_valid, 32'h1);
        check("a5_data", data, 32'hA5);
        check("a5_frame_err", frame_err, 32'h0);
        pulse_read();
        check("a5_pop_valid", rx_valid, 32'h0);
        check("a5_pop_data", data, 32'h00);

        // Glitch: a 4-cycle low pulse must be rejected.
        @(posedge clk); #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_valid", rx_valid, 32'h0);
        check("glitch_frame_err", frame_err, 32'h0);
        check("glitch_overrun", overrun, 32'h0);

        // Fill the FIFO, then overrun it.
        for (int i = 0; i < 5; i++) begin
            send_frame(fill[i], 1'b1, 1'b0);
            if (i == 3) begin
                check("fill4_full", rx_full, 32'h1);
                check("fill4_overrun", overrun, 32'h0);
            end
        end
        check("fill5_overrun", overrun, 32'h1);
        check("fill5_full", rx_full, 32'h1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill_read%0d", i), data, {24'h0, fill[i]});
            pulse_read();
        end
        check("fill_drained", rx_valid, 32'h0);
        pulse_clear();
        check("overrun_cleared", overrun, 32'h0);

        // Framing error.
        send_frame(8'h3C, 1'b0, 1'b0);
        check("frm_frame_err", frame_err, 32'h1);
        check("frm_no_push", rx_valid, 32'h0);
        pulse_clear();
        check("frm_cleared", frame_err, 32'h0);
        send_frame(8'h55, 1'b1, 1'b0);
        check("frm_next_data", data, 32'h55);
        check("frm_next_no_err", frame_err, 32'h0);
        pulse_read();

        // Break: a long low line gives exactly one frame error.
        @(posedge clk); #1 rx = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        check("brk_frame_err", frame_err, 32'h1);
        pulse_clear();
        repeat (50) @(posedge clk);
        #1;
        check("brk_single_err", frame_err, 32'h0);
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("brk_release_err", frame_err, 32'h0);
        check("brk_no_byte", rx_valid, 32'h0);

        // Push and pop in the same cycle while the FIFO is full.
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0);
        check("sp_pre_full", rx_full, 32'h1);
        send_frame(8'h99, 1'b1, 1'b1);
        check("sp_still_full", rx_full, 32'h1);
        check("sp_no_overrun", overrun, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sp_read%0d", i), data, {24'h0, sp[i]});
            pulse_read();
        end
        check("sp_drained", rx_valid, 32'h0);

        // Reset in the middle of a frame.
        send_frame(8'h77, 1'b1, 1'b0);
        check("rst_pre_valid", rx_valid, 32'h1);
        @(posedge clk); #1 rx = 1'b0;                 // start of 0xF0, bits 0..3 are low
        repeat (4 * CPB + CPB / 2) @(posedge clk);    // middle of data bit 3
        #1;
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("midrst");
        repeat (60) @(posedge clk);
        #1;
        check("midrst_no_push", rx_valid, 32'h0);
        send_frame(8'h0F, 1'b1, 1'b0);
        check("midrst_next_valid", rx_valid, 32'h1);
        check("midrst_next_data", data, 32'h0F);
        check("midrst_next_err", frame_err, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver: the receive-side counterpart of the SoC's uart_tx.
- Samples an asynchronous 8N1 line and stores received bytes in a small FIFO.
- Exposes a memory-mapped-friendly pop interface, so the MMU can give the core a UART data register and a status register.
- Line rate is set by CLKS_PER_BIT. No parity and no flow control.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per bit (100 MHz / 115200); must be ≥ 8.
- FIFO_DEPTH, 4: receive FIFO entries; power of two, ≥ 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- rx  input  1  asynchronous serial line, idle high
- read_en  input  1  pop one byte from FIFO head (from MMU decode of core read)
- clear_err  input  1  clear sticky error flags
- data  output  8  FIFO head byte; 0x00 when FIFO empty
- rx_valid  output  1  FIFO not empty
- rx_full  output  1  FIFO full
- frame_err  output  1  sticky: stop bit sampled low
- overrun  output  1  sticky: byte received while FIFO full, byte dropped

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE; all counters and pointers = 0; synchronizer flops = 1.
  - data = 0x00; rx_valid = 0; rx_full = 0; frame_err = 0; overrun = 0.
  - Reset mid-frame abandons the frame; no partial byte is pushed.
- Input path:
  - rx passes through a 2-flop synchronizer (rx_s).
  - The FSM uses rx_s only.
- FSM states:
  - IDLE: rx_s == 0 -> START, bit counter cnt = 0.
  - START: cnt counts to CLKS_PER_BIT/2 - 1, then rx_s is sampled.
    - Sample 0 -> DATA with cnt = 0, bit index = 0.
    - Sample 1 -> IDLE; glitch rejected, nothing recorded.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register, LSB first. After bit index 7 is sampled -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - Sample 1 -> push byte, then IDLE.
    - Sample 0 -> set frame_err, discard byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s == 1, then IDLE. A line held low (break) yields exactly one frame_err and no bytes.
- FIFO:
  - Circular buffer with wr_ptr, rd_ptr, and count of width clog2(FIFO_DEPTH) + 1. Pointers wrap modulo FIFO_DEPTH.
  - Push occurs in the stop-sample cycle; rx_valid and data update on the next clk edge.
  - read_en with count == 0 is ignored: no pointer change, no error.
  - Push with count == FIFO_DEPTH and no pop in the same cycle: byte dropped, overrun set, FIFO contents unchanged.
  - Push and pop in the same cycle: both take effect and count is unchanged. This holds when full too, and does not set overrun.
- Outputs:
  - data = mem[rd_ptr] when count > 0, else 0x00.
  - rx_valid = (count != 0); rx_full = (count == FIFO_DEPTH); both registered from count.
- Error flags:
  - frame_err and overrun are sticky until clear_err or rst.
  - If clear_err and a new error event coincide, the flag ends set (set wins).
- Receive path never stalls; FIFO state does not affect bit timing.

Test Plan (CLKS_PER_BIT = 16, FIFO_DEPTH = 4):
- Single byte: drive 8N1 frame 0xA5 on rx, then idle high.
  -> rx_valid rises within 9.5*16 + 4 cycles of the start falling edge; data = 0xA5; frame_err = 0.
  -> Pulse read_en for 1 cycle -> rx_valid = 0 and data = 0x00 on the next cycle.
- Glitch: pulse rx low for 4 cycles.
  -> State returns to IDLE; rx_valid stays 0; no error flags.
- Fill and overrun: send 0x01, 0x02, 0x03, 0x04, 0x05 with no reads.
  -> rx_full = 1 after the 4th byte; overrun = 1 after the 5th.
  -> Four reads return 0x01 to 0x04 in order (pointer wrap check); then rx_valid = 0.
- Framing: send 0x3C with stop bit low, then line high.
  -> frame_err = 1; no byte pushed.
  -> clear_err -> frame_err = 0.
  -> A following valid 0x55 is received correctly.
- Simultaneous push/pop: with FIFO full, assert read_en in the stop-sample cycle of a 5th byte 0x99.
  -> count stays 4; overrun = 0; the last read returns 0x99.
- Reset mid-frame: assert rst during DATA bit 3 of 0xF0.
  -> All outputs are at reset values next cycle; no byte pushed.
  -> Subsequent frame 0x0F is received correctly.
